// File: rtl/vec_writeback.sv
// ============================================================================
//  Module   : vec_writeback
//  Purpose  : Vector writeback stage. It writes ALU results directly and
//             assembles three 18-bit memory lanes before a single
//             register-file write. Optional macro WB_R15_BLOCK_EN suppresses
//             writes to r15 (PC).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_m,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic [3:0]  wa3m,
    input  logic [53:0] ALUResultM,
    output logic        ready_m,
    input  logic        mem_lane_valid,
    input  logic [17:0] mem_lane_data,
    output logic        RegWriteW,
    output logic [3:0]  wa3w,
    output logic [53:0] wd3
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    localparam logic [3:0] C_PC_ADDR = 4'b1111;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_cnt;
    logic [3:0]  r_addr;
    logic [17:0] r_lane0;
    logic [17:0] r_lane1;

    logic        w_mem_start;
    logic        w_lane_store;
    logic        w_last_lane;
    logic        w_wr_en;
    logic [3:0]  w_wr_addr;
    logic [53:0] w_wr_data;
    logic        w_blk_alu;
    logic        w_blk_mem;

`ifdef WB_R15_BLOCK_EN
    assign w_blk_alu = (wa3m == C_PC_ADDR);
    assign w_blk_mem = (r_addr == C_PC_ADDR);
`else
    assign w_blk_alu = 1'b0;
    assign w_blk_mem = 1'b0;
`endif

    assign ready_m = (r_state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_start  = 1'b0;
        w_lane_store = 1'b0;
        w_last_lane  = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_addr    = wa3m;
        w_wr_data    = ALUResultM;
        case (r_state)
            IDLE: begin
                if (valid_m && RegWriteM) begin
                    if (MemtoRegM) begin
                        w_mem_start  = 1'b1;
                        w_next_state = COLLECT;
                    end else begin
                        w_wr_en = ~w_blk_alu;
                    end
                end
            end
            COLLECT: begin
                if (mem_lane_valid) begin
                    w_lane_store = 1'b1;
                    // Lane 2 bypasses the buffer straight into the write data.
                    if (r_cnt == 2'd2) begin
                        w_last_lane  = 1'b1;
                        w_wr_en      = ~w_blk_mem;
                        w_wr_addr    = r_addr;
                        w_wr_data    = {mem_lane_data, r_lane1, r_lane0};
                        w_next_state = WRITE;
                    end
                end
            end
            WRITE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // RegWriteW is registered, so a write launched on the last lane is
    // visible exactly during the WRITE state cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW <= 1'b0;
            wa3w      <= 4'd0;
            wd3       <= 54'd0;
            r_addr    <= 4'd0;
            r_cnt     <= 2'd0;
            r_lane0   <= 18'd0;
            r_lane1   <= 18'd0;
        end else begin
            RegWriteW <= w_wr_en;
            if (w_wr_en) begin
                wa3w <= w_wr_addr;
                wd3  <= w_wr_data;
            end
            if (w_mem_start) begin
                r_addr <= wa3m;
                r_cnt  <= 2'd0;
            end
            if (w_lane_store) begin
                if (r_cnt == 2'd0) begin
                    r_lane0 <= mem_lane_data;
                end
                if (r_cnt == 2'd1) begin
                    r_lane1 <= mem_lane_data;
                end
                r_cnt <= w_last_lane ? 2'd0 : r_cnt + 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vec_writeback.sv
// ============================================================================
//  Module   : tb_vec_writeback
//  Purpose  : Directed self-checking bench for vec_writeback with a
//             transaction-level reference model and per-cycle comparison.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_writeback;

`ifdef WB_R15_BLOCK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_m = 1'b0;
    logic        RegWriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic [3:0]  wa3m = 4'd0;
    logic [53:0] ALUResultM = 54'd0;
    logic        ready_m;
    logic        mem_lane_valid = 1'b0;
    logic [17:0] mem_lane_data = 18'd0;
    logic        RegWriteW;
    logic [3:0]  wa3w;
    logic [53:0] wd3;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit cmp_en = 1'b0;

    vec_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .valid_m        (valid_m),
        .RegWriteM      (RegWriteM),
        .MemtoRegM      (MemtoRegM),
        .wa3m           (wa3m),
        .ALUResultM     (ALUResultM),
        .ready_m        (ready_m),
        .mem_lane_valid (mem_lane_valid),
        .mem_lane_data  (mem_lane_data),
        .RegWriteW      (RegWriteW),
        .wa3w           (wa3w),
        .wd3            (wd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference model: an instruction is either written at once (ALU) or
    // turns into a pending vector that completes after three lanes arrive.
    bit          m_busy = 1'b0;
    bit          m_wr_cycle = 1'b0;
    logic [3:0]  m_addr = 4'd0;
    logic [17:0] m_lanes[$];
    logic        exp_we = 1'b0;
    logic [3:0]  exp_wa = 4'd0;
    logic [53:0] exp_wd = 54'd0;

    function automatic void model_write(input logic [3:0] a, input logic [53:0] d);
        if (!(BLK && a == 4'hF)) begin
            exp_we = 1'b1;
            exp_wa = a;
            exp_wd = d;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy     = 1'b0;
            m_wr_cycle = 1'b0;
            m_lanes.delete();
            exp_we     = 1'b0;
            exp_wa     = 4'd0;
            exp_wd     = 54'd0;
        end else begin
            exp_we = 1'b0;
            if (m_wr_cycle) begin
                m_wr_cycle = 1'b0;
                m_busy     = 1'b0;
            end else if (!m_busy) begin
                if (valid_m && RegWriteM) begin
                    if (MemtoRegM) begin
                        m_busy = 1'b1;
                        m_addr = wa3m;
                        m_lanes.delete();
                    end else begin
                        model_write(wa3m, ALUResultM);
                    end
                end
            end else if (mem_lane_valid) begin
                m_lanes.push_back(mem_lane_data);
                if (m_lanes.size() == 3) begin
                    model_write(m_addr, {m_lanes[2], m_lanes[1], m_lanes[0]});
                    m_wr_cycle = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready_m",   {63'd0, ready_m},   {63'd0, ~m_busy});
            chk("RegWriteW", {63'd0, RegWriteW}, {63'd0, exp_we});
            chk("wa3w",      {60'd0, wa3w},      {60'd0, exp_wa});
            chk("wd3",       {10'd0, wd3},       {10'd0, exp_wd});
        end
    end

    task automatic idle_inputs();
        valid_m = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0;
        mem_lane_valid = 1'b0;
    endtask

    task automatic issue(input logic rw, input logic m2r, input logic [3:0] a, input logic [53:0] d);
        valid_m = 1'b1; RegWriteM = rw; MemtoRegM = m2r; wa3m = a; ALUResultM = d;
        @(negedge clk);
        valid_m = 1'b0;
    endtask

    task automatic lane(input logic [17:0] d, input int gap);
        mem_lane_valid = 1'b1; mem_lane_data = d;
        @(negedge clk);
        mem_lane_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    localparam logic [17:0] L0 = 18'b101011111111111010;
    localparam logic [17:0] L1 = 18'b111000000111111111;
    localparam logic [17:0] L2 = 18'b101010101000000010;
    localparam logic [53:0] ALU_V = {18'b100000000000000000, 18'b111111111111111111,
                                     18'b101010101010101010};

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        // ALU write with one-cycle latency, then held values
        issue(1'b1, 1'b0, 4'd1, ALU_V);
        chk("alu_we",  {63'd0, RegWriteW}, 64'd1);
        chk("alu_wa",  {60'd0, wa3w}, 64'd1);
        chk("alu_wd",  {10'd0, wd3}, {10'd0, ALU_V});
        @(negedge clk);
        chk("alu_hold_we", {63'd0, RegWriteW}, 64'd0);
        chk("alu_hold_wd", {10'd0, wd3}, {10'd0, ALU_V});

        // memory path, lanes with one-cycle gaps, plus a stalled valid_m
        issue(1'b1, 1'b1, 4'd3, 54'h0);
        chk("mem_busy", {63'd0, ready_m}, 64'd0);
        lane(L0, 1);
        valid_m = 1'b1; RegWriteM = 1'b1; MemtoRegM = 1'b0; wa3m = 4'd9; ALUResultM = 54'h3;
        @(negedge clk);
        valid_m = 1'b0;
        lane(L1, 1);
        lane(L2, 0);
        chk("mem_we",    {63'd0, RegWriteW}, 64'd1);
        chk("mem_wa",    {60'd0, wa3w}, 64'd3);
        chk("mem_wd",    {10'd0, wd3}, {10'd0, L2, L1, L0});
        chk("mem_ready", {63'd0, ready_m}, 64'd0);
        @(negedge clk);
        chk("mem_done_we",    {63'd0, RegWriteW}, 64'd0);
        chk("mem_done_ready", {63'd0, ready_m}, 64'd1);

        // stray lanes in IDLE, RegWriteM=0 instruction, back-to-back ALU
        lane(18'h155AA, 0);
        lane(18'h2AA55, 0);
        issue(1'b0, 1'b0, 4'd7, 54'h1234);
        chk("nowrite_we", {63'd0, RegWriteW}, 64'd0);
        issue(1'b1, 1'b0, 4'd4, 54'h0AAAA_5555_1234);
        issue(1'b1, 1'b0, 4'd5, 54'h15555_AAAA_4321);
        chk("b2b_wa", {60'd0, wa3w}, 64'd5);

        // back-to-back lanes, lane offered during WRITE is discarded
        issue(1'b1, 1'b1, 4'd6, 54'h0);
        lane(18'h00001, 0);
        lane(18'h3FFFE, 0);
        lane(18'h12345, 0);
        lane(18'h0F0F0, 0);
        chk("b2b_mem_wd", {10'd0, wd3}, {10'd0, 18'h12345, 18'h3FFFE, 18'h00001});
        repeat (2) @(negedge clk);

        // asynchronous reset mid-COLLECT after two lanes
        issue(1'b1, 1'b1, 4'd5, 54'h0);
        lane(18'h11111, 0);
        lane(18'h22222, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_we",    {63'd0, RegWriteW}, 64'd0);
        chk("rst_wa",    {60'd0, wa3w}, 64'd0);
        chk("rst_wd",    {10'd0, wd3}, 64'd0);
        chk("rst_ready", {63'd0, ready_m}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        lane(18'h33333, 2);
        issue(1'b1, 1'b0, 4'd2, 54'h2_0000_0002);
        chk("r2_we", {63'd0, RegWriteW}, 64'd1);
        chk("r2_wa", {60'd0, wa3w}, 64'd2);
        @(negedge clk);

        // write to r15
        issue(1'b1, 1'b0, 4'hF, 54'h3_1515_1515);
`ifdef WB_R15_BLOCK_EN
        chk("r15_we", {63'd0, RegWriteW}, 64'd0);
        chk("r15_wa", {60'd0, wa3w}, 64'd2);
`else
        chk("r15_we", {63'd0, RegWriteW}, 64'd1);
        chk("r15_wa", {60'd0, wa3w}, 64'd15);
`endif
        idle_inputs();
        repeat (3) @(negedge clk);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/vec_writeback.md
VEC_WRITEBACK -- requirements
Module: vec_writeback

Interface
REQ-001 Clock and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 valid_m  input  1  memory-stage instruction valid; sampled only when ready_m=1.
REQ-005 RegWriteM  input  1  instruction writes the register file.
REQ-006 MemtoRegM  input  1  1 = result comes from memory lanes, 0 = result is ALUResultM.
REQ-007 wa3m  input  4  destination register index.
REQ-008 ALUResultM  input  3x18  ALU vector result, lane 0 in bits [17:0].
REQ-009 ready_m  output  1  1 = block accepts a new instruction this cycle.
REQ-010 mem_lane_valid  input  1  memory lane data valid this cycle.
REQ-011 mem_lane_data  input  18  one memory lane, delivered in order lane 0, 1, 2.
REQ-012 RegWriteW  output  1  register-file write enable (one-cycle pulse per write).
REQ-013 wa3w  output  4  register-file write address.
REQ-014 wd3  output  3x18  register-file write data, lane 0 in bits [17:0].

Function
REQ-015 FSM states are IDLE, COLLECT and WRITE; ready_m=1 only in IDLE.
REQ-016 In IDLE, accepting valid_m=1 with RegWriteM=1 and MemtoRegM=0 drives RegWriteW=1, wa3w=wa3m and wd3=ALUResultM on the next cycle, then stays in IDLE: one-cycle latency, back-to-back capable.
REQ-017 In IDLE, accepting valid_m=1 with RegWriteM=1 and MemtoRegM=1 captures wa3m, clears the lane counter to 0 and enters COLLECT; RegWriteW=0.
REQ-018 In IDLE, accepting valid_m=1 with RegWriteM=0 causes no write and no state change.
REQ-019 In COLLECT, each cycle with mem_lane_valid=1 stores mem_lane_data into lane[counter] and increments the 2-bit counter; cycles with mem_lane_valid=0 hold all state.
REQ-020 When lane 2 is stored, the next state is WRITE; the counter never exceeds 2.
REQ-021 In WRITE, RegWriteW=1 for exactly one cycle with wa3w = captured address and wd3 = assembled lanes {2,1,0}; the next state is IDLE.
REQ-022 mem_lane_valid in IDLE or WRITE is ignored and discarded.
REQ-023 valid_m while ready_m=0 is not accepted; the upstream stage holds its inputs.
REQ-024 Latency on the memory path is 3 lane cycles plus 1 WRITE cycle from acceptance when lanes arrive back-to-back.
REQ-025 wa3w and wd3 hold their last written values while RegWriteW=0.
REQ-026 No arithmetic is performed; all lanes are passed bit-exact at 18 bits.

Reset
REQ-027 On rst=1, regardless of clk: state=IDLE, counter=0, RegWriteW=0, wa3w=0, wd3=0, and lane buffer=0.
REQ-028 Reset asserted during COLLECT or WRITE discards the partial vector, and no write is issued after reset is released.
REQ-029 While rst=1, ready_m is 1.

Configuration
REQ-030 Macro WB_R15_BLOCK_EN: when defined, any write whose address is 4'b1111 (PC) is suppressed: RegWriteW stays 0, the FSM sequence is unchanged, and wa3w/wd3 are not updated.
REQ-031 Without WB_R15_BLOCK_EN, address 4'b1111 is written like any other register.

Verification
REQ-032 Reset: assert rst mid-cycle -> all outputs 0 immediately, ready_m=1.
REQ-033 ALU write: valid_m=1, RegWriteM=1, MemtoRegM=0, wa3m=4'b0001, ALUResultM lanes {18'b100000000000000000, 18'b111111111111111111, 18'b101010101010101010} -> next cycle RegWriteW=1, wa3w=1, wd3 equals those lanes; the cycle after, RegWriteW=0 and values held.
REQ-034 Memory write: MemtoRegM=1, wa3m=4'b0011, lanes 18'b101011111111111010, 18'b111000000111111111, 18'b101010101000000010 with 1-cycle gaps -> ready_m=0 until WRITE, a single RegWriteW pulse with wa3w=3 and wd3 in lane order, then ready_m=1.
REQ-035 Stall/ignore: valid_m pulsed during COLLECT and stray mem_lane_valid in IDLE -> neither is accepted, and no extra write occurs.
REQ-036 Reset mid-COLLECT after 2 lanes -> no RegWriteW pulse; a subsequent ALU write to r2 completes normally.
REQ-037 With WB_R15_BLOCK_EN, an ALU write to wa3m=4'b1111 -> RegWriteW stays 0; without the macro -> RegWriteW=1 and wa3w=15.
